// File: rtl/lns_mul_stage.sv
// lns_mul_stage: two-stage elastic LNS multiplier front end with sticky ovf/unf status
module lns_mul_stage #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p_out,
  output logic [WIDTH-1:0] c_out,
  output logic             ovf_flag,
  output logic             unf_flag,
  input  logic             clr_flags
);
  localparam int LW = WIDTH - 1;
  localparam logic [LW-1:0] L_MIN = {1'b1, {(LW-1){1'b0}}};
  localparam logic [LW-1:0] L_MAX = {1'b0, {(LW-1){1'b1}}};
  localparam logic [WIDTH-1:0] ZERO = {1'b0, L_MIN};
  localparam logic [WIDTH-1:0] SUM_MAX = {1'b0, L_MAX};
  localparam logic [WIDTH-1:0] SUM_MIN = {1'b1, L_MIN};
  logic             s1_valid, s1_sign, s1_zero;
  logic [WIDTH-1:0] s1_sum, s1_c;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_p, s2_c;
  logic             in_xfer, s2_load, s1_adv;
  logic [WIDTH-1:0] sum_d, p_d;
  logic             zero_d, sat_hi, sat_lo, ovf_ev, unf_ev;
  // handshake: stage 2 refills when empty or draining; stage 1 frees up under the same condition
  always_comb begin
    s2_load  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_load;
    in_ready = !s1_valid || s2_load;
    in_xfer  = in_valid && in_ready;
  end
  // stage-1 datapath: sign-extended log sum and zero-operand detect
  always_comb begin
    sum_d  = {a[LW-1], a[LW-1:0]} + {b[LW-1], b[LW-1:0]};
    zero_d = (a[LW-1:0] == L_MIN) || (b[LW-1:0] == L_MIN);
  end
  // stage-2 datapath: saturate high, flush to zero on underflow, events only for nonzero operands
  always_comb begin
    sat_hi = !s1_zero && ($signed(s1_sum) > $signed(SUM_MAX));
    sat_lo = !s1_zero && ($signed(s1_sum) <= $signed(SUM_MIN));
    p_d    = (s1_zero || sat_lo) ? ZERO : sat_hi ? {s1_sign, L_MAX} : {s1_sign, s1_sum[LW-1:0]};
    ovf_ev = s1_adv && sat_hi;
    unf_ev = s1_adv && sat_lo;
  end
  // stage-1 register: valid follows the input whenever the slot can take a new entry
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sum   <= '0;
      s1_c     <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer) begin
        s1_sign <= a[LW] ^ b[LW];
        s1_zero <= zero_d;
        s1_sum  <= sum_d;
        s1_c    <= c;
      end
    end
  end
  // stage-2 register: holds the result stable while downstream stalls
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_c     <= '0;
    end else begin
      if (s2_load) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_p <= p_d;
        s2_c <= s1_c;
      end
    end
  end
  // sticky status: events raised at stage-2 load override a simultaneous clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      ovf_flag <= ovf_ev || (ovf_flag && !clr_flags);
      unf_flag <= unf_ev || (unf_flag && !clr_flags);
    end
  end
  assign out_valid = s2_valid;
  assign p_out     = s2_p;
  assign c_out     = s2_c;
endmodule

// File: tb/tb_lns_mul_stage.sv
// tb_lns_mul_stage: table-driven and scoreboard checks of the LNS multiplier stage
module tb_lns_mul_stage;
  logic        clk = 1'b0, n_rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
  logic [11:0] a = '0, b = '0, c = '0;
  logic        in_ready, out_valid, ovf_flag, unf_flag;
  logic [11:0] p_out, c_out;
  localparam logic [11:0] ZERO = 12'h400;
  typedef struct {
    logic [11:0] a, b, c, p;
    logic        ovf, unf;
  } vec_t;
  vec_t v[13];
  logic [23:0] q[$];
  int tests = 0, fails = 0;
  logic prev_stall = 1'b0;
  logic [11:0] prev_p, prev_c;

  lns_mul_stage #(.WIDTH(12)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .c_out(c_out), .ovf_flag(ovf_flag), .unf_flag(unf_flag),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] w(input logic s, input int l);
    logic [31:0] t;
    t = l;
    return {s, t[10:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_p", p_out, prev_p);
      chk("stall_c", c_out, prev_c);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got p=%h c=%h expected none", p_out, c_out);
      end else begin
        logic [23:0] e;
        e = q.pop_front();
        chk("sb_p", p_out, e[23:12]);
        chk("sb_c", c_out, e[11:0]);
      end
    end
    prev_stall = n_rst && out_valid && !out_ready;
    prev_p = p_out;
    prev_c = c_out;
  end

  always @(negedge n_rst) prev_stall = 1'b0;

  task automatic send(input vec_t x);
    int n;
    n = 0;
    a = x.a; b = x.b; c = x.c; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    else q.push_back({x.p, x.c});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #3;
    chk("drain_empty", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    v[0]  = '{w(0, 300),   w(1, 400),   w(0, -50),  w(1, 700),   0, 0};
    v[1]  = '{w(0, 800),   w(0, 500),   w(1, 12),   w(0, 1023),  1, 0};
    v[2]  = '{w(1, -700),  w(0, -500),  w(0, 99),   ZERO,        0, 1};
    v[3]  = '{ZERO,        w(1, 1000),  w(1, -3),   ZERO,        0, 0};
    v[4]  = '{w(1, -1024), w(1, 5),     w(0, 7),    ZERO,        0, 0};
    v[5]  = '{w(1, -100),  w(1, -200),  w(1, 444),  w(0, -300),  0, 0};
    v[6]  = '{w(0, 1000),  w(1, 23),    w(0, 1),    w(1, 1023),  0, 0};
    v[7]  = '{w(0, 1000),  w(0, 24),    w(0, 2),    w(0, 1023),  1, 0};
    v[8]  = '{w(1, -1000), w(0, -23),   w(0, 3),    w(1, -1023), 0, 0};
    v[9]  = '{w(1, -1000), w(0, -24),   w(0, 4),    ZERO,        0, 1};
    v[10] = '{w(0, -1023), w(0, -1023), w(1, 5),    ZERO,        0, 1};
    v[11] = '{w(0, 1023),  w(1, 1023),  w(1, 6),    w(1, 1023),  1, 0};
    v[12] = '{w(1, 5),     w(0, -1024), w(0, 8),    ZERO,        0, 0};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf_flag, 0);
    chk("rst_unf", unf_flag, 0);
    chk("rst_p", p_out, 0);
    chk("rst_c", c_out, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
      send(v[i]);
      drain();
      chk($sformatf("vec%0d_ovf", i), ovf_flag, v[i].ovf);
      chk($sformatf("vec%0d_unf", i), unf_flag, v[i].unf);
    end
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    send(v[1]);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #1;
    chk("clr_vs_event", ovf_flag, 1);
    @(negedge clk);
    #1;
    chk("ovf_sticky", ovf_flag, 1);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    #1;
    chk("ovf_cleared", ovf_flag, 0);
    drain();
    begin
      int i;
      i = 0;
      for (int k = 0; k < 12; k++) begin
        out_ready = !(k >= 3 && k < 7);
        if (i < 6) begin
          a = v[i].a; b = v[i].b; c = 12'h100 + 12'(i); in_valid = 1'b1;
        end else in_valid = 1'b0;
        #1;
        if (k < 10) chk($sformatf("bp_in_ready_k%0d", k), in_ready, !(k >= 3 && k < 7));
        if (in_valid && in_ready) begin
          q.push_back({v[i].p, 12'h100 + 12'(i)});
          i++;
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_all_sent", i, 6);
    end
    drain();
    out_ready = 1'b0;
    send(v[1]);
    send(v[0]);
    #1;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    chk("full_ovf", ovf_flag, 1);
    #3;
    n_rst = 1'b0;
    #1;
    chk("amid_out_valid", out_valid, 0);
    chk("amid_ovf", ovf_flag, 0);
    chk("amid_unf", unf_flag, 0);
    chk("amid_p", p_out, 0);
    q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    a = v[5].a; b = v[5].b; c = v[5].c; in_valid = 1'b1;
    q.push_back({v[5].p, v[5].c});
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_cycle2", out_valid, 1);
    @(negedge clk);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lns_mul_stage.md
Name: lns_mul_stage

Overview:
- Pipelined LNS multiplier front end of the fused multiply-add datapath. Computes p = a*b in the 12-bit LNS format.
- Forwards p together with the addend c to the combinational LNS adder that follows it.
- Elastic valid/ready pipeline of two register stages. Also keeps sticky overflow/underflow status for the FMA unit.

Parameters:
- WIDTH, 12, total LNS word width.
  - bit WIDTH-1 is the sign.
  - bits WIDTH-2:0 are the two's-complement log magnitude.
  - The most negative log code encodes zero.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- in_valid  in  1  operands a, b, c valid
- in_ready  out  1  stage accepts operands this cycle
- a  in  WIDTH  LNS multiplicand
- b  in  WIDTH  LNS multiplier
- c  in  WIDTH  LNS addend, passed through unchanged
- out_valid  out  1  p_out/c_out valid
- out_ready  in  1  downstream adder consumes this cycle
- p_out  out  WIDTH  LNS product a*b
- c_out  out  WIDTH  addend aligned with p_out
- ovf_flag  out  1  sticky: a product saturated high
- unf_flag  out  1  sticky: a product underflowed to zero
- clr_flags  in  1  synchronous clear of both sticky flags

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Format with WIDTH=12:
  - Sign is bit 11; log L is bits 10:0, signed, range -1024..1023.
  - Zero is L = -1024, written {0, 11'b100_0000_0000} (ZERO).
  - Any word with L = -1024 is zero regardless of its sign bit.
- Reset (n_rst low, asynchronous):
  - Both stage valid bits clear, so out_valid=0.
  - ovf_flag=0, unf_flag=0.
  - p_out and c_out read 0; their data registers are not required to reset.
  - in_ready=1 once reset is released.
  - Reset asserted mid-stall discards all in-flight operations.
- Stage 1 register (captured on an input transfer, in_valid && in_ready):
  - s1_sign = a[11]^b[11].
  - s1_sum = sign-extended 12-bit La + Lb.
  - s1_zero = (La==-1024) || (Lb==-1024).
  - s1_c = c.
- Stage 2 register (captured when stage 1 advances):
  - If s1_zero: p = ZERO. No flag is raised.
  - Else if s1_sum > 1023: p = {s1_sign, 1023}. Set ovf event.
  - Else if s1_sum <= -1024: p = ZERO (sign forced 0). Set unf event.
  - Else: p = {s1_sign, s1_sum[10:0]}.
  - c is carried unchanged into stage 2.
- Outputs: p_out and c_out come straight from the stage-2 registers; no combinational path from a, b or c.
- Handshake (elastic, no bubbles at full throughput):
  - out transfer = out_valid && out_ready.
  - Stage 2 loads when it is empty or an out transfer occurs in the same cycle.
  - Stage 1 advances into stage 2 under that same condition.
  - in_ready = !s1_valid || stage-2 load condition.
- Latency and throughput:
  - Latency from input transfer to out_valid is 2 cycles with no stall.
  - Sustained throughput is 1 operation per cycle with out_ready held at 1.
- Ordering: results leave in acceptance order. None is dropped or duplicated under any out_ready pattern.
- Stall: while out_valid=1 and out_ready=0, p_out and c_out hold stable.
- Sticky flags:
  - The ovf/unf event is registered when the stage-2 load happens, not when the result is output.
  - Events accumulate (OR) into ovf_flag/unf_flag.
  - clr_flags clears both on the next edge.
  - If clr_flags coincides with an event, the event wins and the flag stays 1.
- A stage-1 valid entry never loses data while blocked.
- in_valid may drop without a transfer; operands are sampled only on a transfer.

Test Plan:
- Normal product: a={0,300}, b={1,400}, c={0,-50}, out_ready=1 → two cycles later p_out={1,700}, c_out={0,-50}, flags 0.
- Overflow: a={0,800}, b={0,500} (sum 1300) → p_out={0,1023}, ovf_flag=1 and it stays 1. Then pulse clr_flags → ovf_flag=0.
- Underflow: a={1,-700}, b={0,-500} (sum -1200) → p_out=ZERO, sign 0, unf_flag=1.
- Zero operand: a=ZERO, b={1,1000} → p_out=ZERO, no flag. Also a={1,-1024}, b={1,5} → p_out=ZERO.
- Backpressure: stream 6 operations with distinct c on consecutive cycles, hold out_ready=0 for 4 cycles in the middle.
  - in_ready drops after two operations are buffered.
  - Outputs hold stable during the stall.
  - All 6 emerge in order with correct p and no duplicates.
- Reset mid-stall: with both stages full, assert n_rst low asynchronously between edges → out_valid=0 immediately, flags 0. After release, in_ready=1 and the next operation completes with 2-cycle latency.
